// File: rtl/selector_recuadros_if.sv
// Handshake bundle between the UI controller and the selector_recuadros focus/colour block.
interface selector_recuadros_if;
  logic        frame_tick;
  logic        btn_next;
  logic        btn_prev;
  logic        btn_enter;
  logic        btn_exit;
  logic [1:0]  sel_box;
  logic        edit_mode;
  logic [11:0] rgb_hora;
  logic [11:0] rgb_fecha;
  logic [11:0] rgb_timer;
  logic [11:0] rgb_config;

  modport master (
    output frame_tick, btn_next, btn_prev, btn_enter, btn_exit,
    input  sel_box, edit_mode, rgb_hora, rgb_fecha, rgb_timer, rgb_config
  );

  modport slave (
    input  frame_tick, btn_next, btn_prev, btn_enter, btn_exit,
    output sel_box, edit_mode, rgb_hora, rgb_fecha, rgb_timer, rgb_config
  );
endinterface

// File: rtl/selector_recuadros.sv
// Focus sequencer over the four screen boxes with frame-synchronous border colours.
// Optional NAV idle timeout enabled by defining SELECTOR_TIMEOUT_EN.
module selector_recuadros #(
  parameter int          BLINK_FRAMES   = 30,
  parameter int          TIMEOUT_FRAMES = 600,
  parameter logic [11:0] HILITE_RGB     = 12'hFFF,
  parameter logic [11:0] RGB_HORA       = 12'hF00,
  parameter logic [11:0] RGB_FECHA      = 12'h00F,
  parameter logic [11:0] RGB_TIMER      = 12'h4F0,
  parameter logic [11:0] RGB_CONFIG     = 12'h0FF
) (
  input  logic               clk,
  input  logic               reset,
  selector_recuadros_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_NAV  = 2'd1;
  localparam logic [1:0] ST_EDIT = 2'd2;

  localparam int         BW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  function automatic logic [11:0] default_rgb(input logic [1:0] idx);
    logic [11:0] c;
    case (idx)
      2'd0:    c = RGB_HORA;
      2'd1:    c = RGB_FECHA;
      2'd2:    c = RGB_TIMER;
      2'd3:    c = RGB_CONFIG;
      default: c = RGB_HORA;
    endcase
    return c;
  endfunction

  logic [1:0]    state_r, state_s;
  logic [1:0]    sel_r, sel_s;
  logic          edit_r;
  logic [BW-1:0] blink_cnt_r, blink_cnt_s;
  logic          phase_r, phase_s;
  logic [11:0]   rgb_r [4];
  logic [11:0]   tgt_s [4];
  logic          do_exit_s, do_enter_s, do_next_s, do_prev_s, any_btn_s;

  // Button priority decode: exit > enter > next > prev, next+prev together cancel.
  always_comb begin
    do_exit_s  = bus.btn_exit;
    do_enter_s = !bus.btn_exit && bus.btn_enter;
    do_next_s  = !bus.btn_exit && !bus.btn_enter && bus.btn_next && !bus.btn_prev;
    do_prev_s  = !bus.btn_exit && !bus.btn_enter && bus.btn_prev && !bus.btn_next;
    any_btn_s  = bus.btn_exit | bus.btn_enter | bus.btn_next | bus.btn_prev;
  end

`ifdef SELECTOR_TIMEOUT_EN
  localparam int           TW      = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_FRAMES - 1);
  logic [TW-1:0] to_cnt_r, to_cnt_s;
  logic          to_hit_s;

  // NAV idle counter: any button pulse (even an ignored one) restarts it.
  always_comb begin
    to_hit_s = 1'b0;
    if (state_r != ST_NAV || any_btn_s) begin
      to_cnt_s = '0;
    end else if (bus.frame_tick) begin
      to_hit_s = (to_cnt_r == TO_LAST);
      to_cnt_s = to_hit_s ? '0 : to_cnt_r + TW'(1);
    end else begin
      to_cnt_s = to_cnt_r;
    end
  end

  // Idle counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) to_cnt_r <= '0;
    else       to_cnt_r <= to_cnt_s;
  end
`endif

  // Next-state, focus and blink logic.
  always_comb begin
    state_s     = state_r;
    sel_s       = sel_r;
    blink_cnt_s = blink_cnt_r;
    phase_s     = phase_r;
    case (state_r)
      ST_IDLE: begin
        if (do_enter_s || do_next_s || do_prev_s) state_s = ST_NAV;
        else                                       state_s = ST_IDLE;
      end
      ST_NAV: begin
        if (do_exit_s) begin
          state_s = ST_IDLE;
        end else if (do_enter_s) begin
          state_s     = ST_EDIT;
          blink_cnt_s = '0;
          phase_s     = 1'b1;
        end else if (do_next_s) begin
          sel_s = sel_r + 2'd1;
        end else if (do_prev_s) begin
          sel_s = sel_r - 2'd1;
        end else begin
`ifdef SELECTOR_TIMEOUT_EN
          if (to_hit_s) state_s = ST_IDLE;
          else          state_s = ST_NAV;
`else
          state_s = ST_NAV;
`endif
        end
      end
      ST_EDIT: begin
        if (do_exit_s) begin
          state_s     = ST_NAV;
          blink_cnt_s = '0;
          phase_s     = 1'b1;
        end else if (bus.frame_tick) begin
          if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_s = '0;
            phase_s     = ~phase_r;
          end else begin
            blink_cnt_s = blink_cnt_r + BW'(1);
          end
        end else begin
          blink_cnt_s = blink_cnt_r;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        blink_cnt_s = '0;
        phase_s     = 1'b1;
      end
    endcase
  end

  // Colour target from the current (pre-button) state.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if ((sel_r == 2'(i)) &&
          ((state_r == ST_NAV) || ((state_r == ST_EDIT) && phase_r)))
        tgt_s[i] = HILITE_RGB;
      else
        tgt_s[i] = default_rgb(2'(i));
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      sel_r       <= 2'd0;
      edit_r      <= 1'b0;
      blink_cnt_r <= '0;
      phase_r     <= 1'b1;
    end else begin
      state_r     <= state_s;
      sel_r       <= sel_s;
      edit_r      <= (state_s == ST_EDIT);
      blink_cnt_r <= blink_cnt_s;
      phase_r     <= phase_s;
    end
  end

  // Colours only move in vertical blank so a frame never tears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) rgb_r[i] <= default_rgb(2'(i));
    end else if (bus.frame_tick) begin
      for (int i = 0; i < 4; i++) rgb_r[i] <= tgt_s[i];
    end
  end

  assign bus.sel_box    = sel_r;
  assign bus.edit_mode  = edit_r;
  assign bus.rgb_hora   = rgb_r[0];
  assign bus.rgb_fecha  = rgb_r[1];
  assign bus.rgb_timer  = rgb_r[2];
  assign bus.rgb_config = rgb_r[3];

endmodule
